// File: rtl/pwm_bank.sv
// pwm_bank -- multi-channel PWM generator with a shared time base.
//
// All channels share one prescaler and one period counter. Each channel has a
// double-buffered duty: writes land in a shadow register and move to the
// active register only at a period boundary, so no period is ever cut short
// or stretched. A channel in breathing mode ignores its shadow and instead
// ramps its own duty up and down by one tick per period.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   en         run enable for the prescaler and period counter
//   duty_wr    single-cycle duty write strobe
//   duty_ch    channel index for the write
//   duty_val   requested duty in ticks (stored clamped to PERIOD+1)
//   breath     per-channel breathing-mode enable
//   pwm_out    PWM outputs, polarity applied
//   cnt        current period-counter value
//   period_tc  one-cycle pulse on the tick where cnt wraps PERIOD -> 0
//
// Write handshake: duty_wr has no ready; the block accepts a write on every
// rising edge where duty_wr=1, whatever the state of en. A write to an index
// with no channel behind it is dropped.
module pwm_bank #(
  parameter int CHANNELS   = 8,
  parameter int CW         = 4,
  parameter int PERIOD     = 9,
  parameter int PRESCALE   = 26999,
  parameter int ACTIVE_LOW = 1,
  localparam int DW        = CW + 1,
  localparam int CHW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                duty_wr,
  input  logic [CHW-1:0]      duty_ch,
  input  logic [DW-1:0]       duty_val,
  input  logic [CHANNELS-1:0] breath,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CW-1:0]       cnt,
  output logic                period_tc
);

  localparam logic [25:0]   PRE_TC = 26'(PRESCALE);
  localparam logic [CW-1:0] CNT_TC = CW'(PERIOD);
  // FULL is the "always on" duty; TOP is the first step down from it.
  localparam logic [DW-1:0] FULL   = DW'(PERIOD + 1);
  localparam logic [DW-1:0] TOP    = DW'(PERIOD);
  localparam logic          ON_LVL = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  logic [25:0]   pre;
  logic          tick;
  logic          wrap;
  logic [DW-1:0] duty_clamped;

  assign tick      = en && (pre == PRE_TC);
  assign wrap      = tick && (cnt == CNT_TC);
  assign period_tc = wrap;

  // Clamping at write time keeps every stored duty within 0..PERIOD+1, which
  // is what lets the breathing ramp and the output compare stay at DW bits.
  assign duty_clamped = (duty_val > FULL) ? FULL : duty_val;

  // Prescaler: holds while en=0 so a paused period resumes where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PRE_TC) ? '0 : pre + 26'd1;
    end
  end

  // Period counter: advances only on prescaler ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == CNT_TC) ? '0 : cnt + CW'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [CHW-1:0] CH_IDX = CHW'(g);

    logic [DW-1:0] shadow;
    logic [DW-1:0] active;
    logic          dir;    // 1 = ramping up

    // Each channel decodes its own index, so indices beyond CHANNELS-1
    // simply match nothing.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow <= '0;
      end else if (duty_wr && (duty_ch == CH_IDX)) begin
        shadow <= duty_clamped;
      end
    end

    // The active duty only moves at a wrap. A write landing on the same edge
    // as the wrap updates shadow, while active picks up the previous shadow.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        active <= '0;
        dir    <= 1'b1;
      end else if (wrap) begin
        if (!breath[g]) begin
          active <= shadow;
          dir    <= 1'b1;
        end else if (dir) begin
          if (active >= FULL) begin
            active <= TOP;
            dir    <= 1'b0;
          end else begin
            active <= active + DW'(1);
          end
        end else begin
          if (active == '0) begin
            active <= DW'(1);
            dir    <= 1'b1;
          end else begin
            active <= active - DW'(1);
          end
        end
      end
    end

    // Zero-extended cnt against active: 0 is always off, PERIOD+1 always on.
    assign pwm_out[g] = ({1'b0, cnt} < active) ? ON_LVL : ~ON_LVL;
  end

endmodule
